// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port: request/ready handshake.
// The fetch unit drives the request; memory returns the word.
interface instruction_fetch_unit_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_data
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads halfword instructions from
// instruction memory and holds them in IR for decode.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned PC_STEP   = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  instruction_fetch_unit_if.master       mem,
  input  logic                           i_advance,
  input  logic                           i_jump_enable,
  input  logic [10:0]                    i_jump_immediate,
  input  logic                           i_branch_enable,
  input  logic [15:0]                    i_branch_target,
  output logic [4:0]                     o_opcode,
  output logic [10:0]                    o_instr_param,
  output logic [15:0]                    o_pcout,
  output logic                           o_instr_valid
);

  typedef enum logic {S_REQ, S_VALID} state_t;

  localparam logic [15:0] STEP = 16'(PC_STEP);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_fetch_addr, w_fetch_addr_nxt;
  logic [15:0] r_ir, w_ir_nxt;
  logic [15:0] r_pcout, w_pcout_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_squash, w_squash_nxt;

  logic        w_redirect;
  logic [15:0] w_target;
  logic [15:0] w_fetch_inc;

  // Jump wins over branch; both targets are forced even.
  always_comb begin
    w_redirect  = i_jump_enable | i_branch_enable;
    w_target    = i_jump_enable
                ? {r_pcout[15:12], i_jump_immediate, 1'b0}
                : {i_branch_target[15:1], 1'b0};
    w_fetch_inc = r_fetch_addr + STEP;
  end

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_fetch_addr_nxt = r_fetch_addr;
    w_ir_nxt         = r_ir;
    w_pcout_nxt      = r_pcout;
    w_valid_nxt      = r_valid;
    w_squash_nxt     = r_squash;
    unique case (r_state)
      S_REQ: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_ir_nxt    = NOP_INSTR;
          w_valid_nxt = 1'b0;
          if (mem.mem_ready) begin
            w_squash_nxt     = 1'b0;
            w_fetch_addr_nxt = w_target;
          end else begin
            w_squash_nxt = 1'b1;
          end
        end else if (mem.mem_ready) begin
          if (r_squash) begin
            w_squash_nxt     = 1'b0;
            w_fetch_addr_nxt = r_pc;
          end else begin
            w_ir_nxt    = mem.mem_data;
            w_pcout_nxt = w_fetch_inc;
            w_pc_nxt    = w_fetch_inc;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (w_redirect) begin
          w_pc_nxt         = w_target;
          w_ir_nxt         = NOP_INSTR;
          w_valid_nxt      = 1'b0;
          w_fetch_addr_nxt = w_target;
          w_state_nxt      = S_REQ;
        end else if (i_advance) begin
          w_valid_nxt      = 1'b0;
          w_fetch_addr_nxt = r_pc;
          w_state_nxt      = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_ir         <= NOP_INSTR;
      r_pcout      <= RESET_PC;
      r_valid      <= 1'b0;
      r_squash     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_ir         <= w_ir_nxt;
      r_pcout      <= w_pcout_nxt;
      r_valid      <= w_valid_nxt;
      r_squash     <= w_squash_nxt;
    end
  end

  // No request is presented while reset is held.
  always_comb begin
    mem.mem_req   = (r_state == S_REQ) & ~i_reset;
    mem.mem_addr  = r_fetch_addr;
    o_opcode      = r_ir[15:11];
    o_instr_param = r_ir[10:0];
    o_pcout       = r_pcout;
    o_instr_valid = r_valid;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Memory handshake is driven by hand per vector.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        advance;
  logic        jump_en;
  logic [10:0] jump_imm;
  logic        branch_en;
  logic [15:0] branch_tgt;
  logic [4:0]  opcode;
  logic [10:0] param;
  logic [15:0] pcout;
  logic        valid;

  int n_chk;
  int n_err;

  instruction_fetch_unit_if mem_if ();

  instruction_fetch_unit dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .mem              (mem_if.master),
    .i_advance        (advance),
    .i_jump_enable    (jump_en),
    .i_jump_immediate (jump_imm),
    .i_branch_enable  (branch_en),
    .i_branch_target  (branch_tgt),
    .o_opcode         (opcode),
    .o_instr_param    (param),
    .o_pcout          (pcout),
    .o_instr_valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    advance   = 1'b0;
    jump_en   = 1'b0;
    branch_en = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    idle_ctl();
    jump_imm   = '0;
    branch_tgt = '0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_data  = '0;
    tick();
    tick();
    chk("rst_req",   32'(mem_if.mem_req), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_pcout", 32'(pcout), 32'h0);
    chk("rst_op",    32'(opcode), 32'h0);

    // 1: first fetch, memory ready on third cycle
    rst = 1'b0;
    #1;
    chk("t1_req0",  32'(mem_if.mem_req), 32'h1);
    chk("t1_addr0", 32'(mem_if.mem_addr), 32'h0);
    tick();
    chk("t1_addr1", 32'(mem_if.mem_addr), 32'h0);
    tick();
    chk("t1_addr2", 32'(mem_if.mem_addr), 32'h0);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_data  = 16'h1234;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t1_op",    32'(opcode), 32'h02);
    chk("t1_param", 32'(param), 32'h234);
    chk("t1_pcout", 32'(pcout), 32'h2);
    chk("t1_valid", 32'(valid), 32'h1);
    chk("t1_noreq", 32'(mem_if.mem_req), 32'h0);

    // 2: straight-line zero-wait fetches
    for (int i = 1; i <= 3; i++) begin
      advance = 1'b1;
      tick();
      advance = 1'b0;
      chk("t2_addr",  32'(mem_if.mem_addr), 32'(2 * i));
      chk("t2_inval", 32'(valid), 32'h0);
      mem_if.mem_ready = 1'b1;
      mem_if.mem_data  = 16'(16'h0800 * i);
      tick();
      mem_if.mem_ready = 1'b0;
      chk("t2_pcout", 32'(pcout), 32'(2 * i + 2));
      chk("t2_op",    32'(opcode), 32'(i));
    end

    // 3: wrap from 0xFFFE
    branch_en  = 1'b1;
    branch_tgt = 16'hFFFE;
    tick();
    idle_ctl();
    chk("t3_addr", 32'(mem_if.mem_addr), 32'hFFFE);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_data  = 16'hABCD;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t3_pcout", 32'(pcout), 32'h0);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    chk("t3_next", 32'(mem_if.mem_addr), 32'h0);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_data  = 16'h0000;
    tick();
    mem_if.mem_ready = 1'b0;

    // 4: jump from PCOUT=0x3006, then jump+branch
    branch_en  = 1'b1;
    branch_tgt = 16'h3005;
    tick();
    idle_ctl();
    chk("t4_baddr", 32'(mem_if.mem_addr), 32'h3004);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_data  = 16'h1111;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t4_pcout", 32'(pcout), 32'h3006);
    jump_en  = 1'b1;
    jump_imm = 11'h155;
    tick();
    idle_ctl();
    chk("t4_jaddr", 32'(mem_if.mem_addr), 32'h32AA);
    chk("t4_inval", 32'(valid), 32'h0);
    chk("t4_nop",   32'(opcode), 32'h0);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_data  = 16'h2222;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t4_pc2", 32'(pcout), 32'h32AC);
    jump_en    = 1'b1;
    branch_en  = 1'b1;
    jump_imm   = 11'h0FF;
    branch_tgt = 16'h0400;
    tick();
    idle_ctl();
    chk("t4_prio", 32'(mem_if.mem_addr), 32'h31FE);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_data  = 16'h3333;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t4_pc3", 32'(pcout), 32'h3200);

    // 5: branch while a request is stalled
    advance = 1'b1;
    tick();
    advance = 1'b0;
    chk("t5_addr0", 32'(mem_if.mem_addr), 32'h3200);
    tick();
    branch_en  = 1'b1;
    branch_tgt = 16'h0101;
    tick();
    idle_ctl();
    chk("t5_hold1", 32'(mem_if.mem_addr), 32'h3200);
    chk("t5_req",   32'(mem_if.mem_req), 32'h1);
    chk("t5_inv1",  32'(valid), 32'h0);
    tick();
    chk("t5_hold2", 32'(mem_if.mem_addr), 32'h3200);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_data  = 16'hFFFF;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t5_inv2", 32'(valid), 32'h0);
    chk("t5_nop",  32'(opcode), 32'h0);
    chk("t5_new",  32'(mem_if.mem_addr), 32'h0100);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_data  = 16'h5555;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t5_val",   32'(valid), 32'h1);
    chk("t5_op",    32'(opcode), 32'h0A);
    chk("t5_pcout", 32'(pcout), 32'h0102);

    // 6: reset mid-request with memory ready
    advance = 1'b1;
    tick();
    advance = 1'b0;
    chk("t6_addr", 32'(mem_if.mem_addr), 32'h0102);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_data  = 16'h7777;
    rst = 1'b1;
    tick();
    chk("t6_inval", 32'(valid), 32'h0);
    chk("t6_nop",   32'(opcode), 32'h0);
    chk("t6_par",   32'(param), 32'h0);
    chk("t6_noreq", 32'(mem_if.mem_req), 32'h0);
    rst = 1'b0;
    mem_if.mem_ready = 1'b0;
    #1;
    chk("t6_addr0", 32'(mem_if.mem_addr), 32'h0);
    chk("t6_req",   32'(mem_if.mem_req), 32'h1);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_data  = 16'h0800;
    tick();
    mem_if.mem_ready = 1'b0;
    chk("t6_pcout", 32'(pcout), 32'h2);
    chk("t6_op",    32'(opcode), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
